// File: rtl/wb_rr_arbiter.sv
// Wishbone N-master to single-slave arbiter: round-robin or fixed priority,
// one grant at a time, with a slave response timeout that errors the granted master.
module wb_rr_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RR_MODE     = 1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]   wbm_dat_i,
    output logic [NUM_MASTERS*DATA_W-1:0]   wbm_dat_o,
    input  logic [NUM_MASTERS-1:0]          wbm_we_i,
    input  logic [NUM_MASTERS-1:0]          wbm_stb_i,
    input  logic [NUM_MASTERS-1:0]          wbm_cyc_i,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] wbm_sel_i,
    output logic [NUM_MASTERS-1:0]          wbm_ack_o,
    output logic [NUM_MASTERS-1:0]          wbm_err_o,
    output logic [NUM_MASTERS-1:0]          wbm_rty_o,
    output logic [ADDR_W-1:0]               wbs_adr_o,
    output logic [DATA_W-1:0]               wbs_dat_o,
    output logic                            wbs_we_o,
    output logic [DATA_W/8-1:0]             wbs_sel_o,
    output logic                            wbs_stb_o,
    output logic                            wbs_cyc_o,
    input  logic [DATA_W-1:0]               wbs_dat_i,
    input  logic                            wbs_ack_i,
    input  logic                            wbs_err_i,
    input  logic                            wbs_rty_i,
    output logic [NUM_MASTERS-1:0]          grant_o,
    output logic                            timeout_o
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] base;
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] winner;
    logic             found;
    logic             slv_resp;
    logic             timeout_fire;
    logic             granted;

    assign granted  = (state_q == ST_GRANT);
    assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

    // A real slave response in the expiry cycle takes precedence over the timeout.
    assign timeout_fire = (TIMEOUT != 0) && granted && (cnt_q == CNT_MAX) && !slv_resp;
    assign timeout_o    = timeout_fire;

    // Scan from ptr (round-robin) or from 0 (fixed), wrapping modulo NUM_MASTERS.
    always_comb begin
        base   = (RR_MODE != 0) ? ptr_q : '0;
        cand   = '0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = {1'b0, base} + (IDX_W + 1)'(i);
            if (cand >= (IDX_W + 1)'(NUM_MASTERS)) begin
                cand = cand - (IDX_W + 1)'(NUM_MASTERS);
            end
            if (!found && wbm_cyc_i[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (found) begin
                    idx_d   = winner;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!wbm_cyc_i[idx_q]) begin
                    state_d = ST_IDLE;
                    if (RR_MODE != 0) begin
                        ptr_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end
                end
                if (!wbm_stb_i[idx_q] || slv_resp || timeout_fire) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slave side mirrors the granted master; everything is 0 while idle.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_we_o  = 1'b0;
        wbs_sel_o = '0;
        wbs_stb_o = 1'b0;
        wbs_cyc_o = 1'b0;
        grant_o   = '0;
        if (granted) begin
            wbs_adr_o      = wbm_adr_i[idx_q*ADDR_W +: ADDR_W];
            wbs_dat_o      = wbm_dat_i[idx_q*DATA_W +: DATA_W];
            wbs_we_o       = wbm_we_i[idx_q];
            wbs_sel_o      = wbm_sel_i[idx_q*SEL_W +: SEL_W];
            wbs_stb_o      = wbm_stb_i[idx_q] & ~timeout_fire;
            wbs_cyc_o      = wbm_cyc_i[idx_q];
            grant_o[idx_q] = 1'b1;
        end
    end

    assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
    assign wbm_ack_o = grant_o & {NUM_MASTERS{wbs_ack_i}};
    assign wbm_err_o = grant_o & {NUM_MASTERS{wbs_err_i | timeout_fire}};
    assign wbm_rty_o = grant_o & {NUM_MASTERS{wbs_rty_i}};

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of Wishbone masters; legal range 2..8.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width; a multiple of 8.
REQ-004 Parameter RR_MODE, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, lowest index wins.
REQ-005 Parameter TIMEOUT, default 255: cycles the arbiter waits for the slave to respond; 0 disables the timeout.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 wbm_adr_i  in  NUM_MASTERS*ADDR_W  per-master address; master k occupies slice k.
REQ-009 wbm_dat_i  in  NUM_MASTERS*DATA_W  per-master write data.
REQ-010 wbm_dat_o  out  NUM_MASTERS*DATA_W  read data to each master.
REQ-011 wbm_we_i / wbm_stb_i / wbm_cyc_i  in  NUM_MASTERS each  per-master write enable, strobe and cycle.
REQ-012 wbm_sel_i  in  NUM_MASTERS*DATA_W/8  per-master byte selects.
REQ-013 wbm_ack_o / wbm_err_o / wbm_rty_o  out  NUM_MASTERS each  per-master responses.
REQ-014 wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o  out  ADDR_W, DATA_W, 1, DATA_W/8, 1, 1  slave side.
REQ-015 wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i  in  DATA_W, 1, 1, 1  slave responses.
REQ-016 grant_o  out  NUM_MASTERS  one-hot current grant; all zero when idle.
REQ-017 timeout_o  out  1  one-cycle pulse when a timeout fires.

Function
REQ-018 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-019 In IDLE with any wbm_cyc_i set, the block SHALL register the winner's index, set grant_o, and enter GRANT on the next edge: one cycle request-to-wbs_cyc_o latency.
REQ-020 Winner selection: fixed mode picks the lowest set index; round-robin picks the first set index at or after ptr, wrapping modulo NUM_MASTERS.
REQ-021 On leaving GRANT, round-robin mode SHALL set ptr = (granted index + 1) mod NUM_MASTERS; fixed mode SHALL leave ptr unused.
REQ-022 In GRANT, wbs_adr_o, dat_o, we_o, sel_o, stb_o and cyc_o SHALL combinationally mirror the granted master's inputs.
REQ-023 In IDLE, wbs_cyc_o and wbs_stb_o SHALL be 0; the other slave outputs are don't-care and are driven 0.
REQ-024 Slave ack/err/rty SHALL route only to the granted master; all other masters SHALL see 0.
REQ-025 wbs_dat_i SHALL broadcast to every wbm_dat_o slice.
REQ-026 GRANT SHALL persist while the granted wbm_cyc_i is 1, covering multi-beat and locked cycles.
REQ-027 When the granted wbm_cyc_i is 0, the block SHALL return to IDLE on the next edge; at least one idle cycle separates consecutive grants.
REQ-028 Requests from other masters during GRANT SHALL be ignored until the block returns to IDLE.
REQ-029 The timeout counter SHALL clear when any of the following holds: IDLE, granted wbs_stb_o = 0, or any slave ack/err/rty.
REQ-030 Otherwise the timeout counter SHALL increment, saturating at TIMEOUT.
REQ-031 When the counter equals TIMEOUT (TIMEOUT ≠ 0), the block SHALL, for one cycle:
- assert wbm_err_o to the granted master;
- force wbs_stb_o to 0;
- pulse timeout_o;
- clear the counter.
REQ-032 The timeout SHALL NOT release the grant; the master ends the cycle by dropping cyc.
REQ-033 A slave response arriving in the same cycle as the timeout SHALL win: it is forwarded and no timeout fires.
REQ-034 The counter SHALL be ceil(log2(TIMEOUT+1)) bits wide, minimum 1.

Reset
REQ-035 While rst = 0, asynchronously:
- state = IDLE, ptr = 0, counter = 0;
- grant_o = 0, timeout_o = 0;
- wbs_cyc_o = 0, wbs_stb_o = 0;
- all wbm_ack_o, wbm_err_o, wbm_rty_o = 0.
REQ-036 Reset asserted mid-transfer SHALL abandon the transfer with no response pulse to any master.
REQ-037 Arbitration SHALL begin on the first rising edge after rst deasserts.

Verification
REQ-038 NUM_MASTERS=4, RR_MODE=1: all cyc_i held at 1, each cycle lasting 2 beats -> grant_o sequence 0001, 0010, 0100, 1000, 0001, with an idle cycle between each grant.
REQ-039 RR_MODE=0: masters 1 and 3 request continuously -> master 1 re-granted every time; master 3 starves.
REQ-040 Master 2 request with a slave that never responds, TIMEOUT=4 -> wbm_err_o[2] and timeout_o pulse 4 cycles after stb; no other master sees the error; grant is held until cyc_i[2] drops.
REQ-041 Slave ack arriving exactly on the TIMEOUT cycle -> ack_o forwarded, no err_o, no timeout_o.
REQ-042 rst pulsed low mid-burst while master 0 holds the grant -> wbs_cyc_o = 0 immediately, grant_o = 0, ptr = 0; master 0 is re-granted after release if it still requests.
REQ-043 Master 1 write with sel_i = 4'b0110, adr = 0x100 -> wbs_sel_o = 0110 and wbs_adr_o = 0x100 one cycle after the request.
